// File: rtl/icache_pref_responder_pkg.sv
// Shared types for the icache prefetch responder: MSHR entry layout,
// memory command encoding and the default number of outstanding prefetches.
`ifndef PREF_MSHR_SIZE
`define PREF_MSHR_SIZE 4
`endif

package icache_pref_responder_pkg;

    localparam int PREF_MSHR_DEFAULT = `PREF_MSHR_SIZE;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'h0,
        MEM_LOAD  = 2'h1,
        MEM_STORE = 2'h2
    } mem_command_t;

    typedef enum logic [1:0] {
        INVALID = 2'h0,
        REQ     = 2'h1,
        PENDING = 2'h2
    } mshr_state_t;

    typedef struct packed {
        mshr_state_t state;
        logic [31:0] addr;
        logic [3:0]  tag;
    } mshr_entry_t;

    // Memory blocks are 8 bytes; drop the byte offset.
    function automatic logic [31:0] block_addr(input logic [31:0] a);
        return {a[31:3], 3'b000};
    endfunction

endpackage

// File: rtl/icache_pref_responder_pe.sv
// Lowest-index priority encoder shared by allocation, issue and fill lookup.
module pref_pe #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Scan high to low so the lowest set bit is the last one assigned.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/icache_pref_responder.sv
// Tracks outstanding instruction prefetches: filters duplicates and hits,
// issues block loads to memory, and forwards returning lines as icache fills.
module icache_pref_responder
    import icache_pref_responder_pkg::*;
#(
    parameter int PREF_MSHR_SIZE = PREF_MSHR_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pref2Icache_addr,
    input  logic        pref2Icache_valid,
    input  logic        cache_hit,
    output logic        hit_valid_line,
    input  logic        mem_grant,
    output logic [1:0]  proc2mem_command,
    output logic [31:0] proc2mem_addr,
    input  logic [3:0]  mem2proc_transaction_tag,
    input  logic [3:0]  mem2proc_data_tag,
    input  logic [63:0] mem2proc_data,
    input  logic        flush,
    output logic        fill_valid,
    output logic [31:0] fill_addr,
    output logic [63:0] fill_data
);

    localparam int IW = (PREF_MSHR_SIZE > 1) ? $clog2(PREF_MSHR_SIZE) : 1;

    mshr_entry_t entries_q [PREF_MSHR_SIZE];
    mshr_entry_t entries_d [PREF_MSHR_SIZE];

    logic [PREF_MSHR_SIZE-1:0] invalid_vec;
    logic [PREF_MSHR_SIZE-1:0] req_vec;
    logic [PREF_MSHR_SIZE-1:0] dup_vec;
    logic [PREF_MSHR_SIZE-1:0] fill_vec;

    logic [IW-1:0] alloc_idx;
    logic [IW-1:0] issue_idx;
    logic [IW-1:0] fill_idx;
    logic          alloc_found;
    logic          issue_found;
    logic          fill_found;

    logic [31:0] req_blk;
    logic        covered;
    logic        do_alloc;
    logic        do_issue;

    assign req_blk = block_addr(pref2Icache_addr);

    // Per-entry status vectors, all from registered state so a slot freed
    // this cycle only becomes visible next cycle.
    generate
        for (genvar gi = 0; gi < PREF_MSHR_SIZE; gi++) begin : g_vec
            assign invalid_vec[gi] = (entries_q[gi].state == INVALID);
            assign req_vec[gi]     = (entries_q[gi].state == REQ);
            assign dup_vec[gi]     = (entries_q[gi].state != INVALID) &&
                                     (entries_q[gi].addr == req_blk);
            assign fill_vec[gi]    = (entries_q[gi].state == PENDING) &&
                                     (mem2proc_data_tag != 4'h0) &&
                                     (entries_q[gi].tag == mem2proc_data_tag);
        end
    endgenerate

    pref_pe #(.N(PREF_MSHR_SIZE)) u_alloc_pe (
        .req   (invalid_vec),
        .idx   (alloc_idx),
        .found (alloc_found)
    );

    pref_pe #(.N(PREF_MSHR_SIZE)) u_issue_pe (
        .req   (req_vec),
        .idx   (issue_idx),
        .found (issue_found)
    );

    pref_pe #(.N(PREF_MSHR_SIZE)) u_fill_pe (
        .req   (fill_vec),
        .idx   (fill_idx),
        .found (fill_found)
    );

    // An entry being filled is still valid this cycle, so a request for the
    // same block is reported as covered through the duplicate match.
    assign covered        = pref2Icache_valid && (cache_hit || (|dup_vec) || !alloc_found);
    assign hit_valid_line = covered;
    assign do_alloc       = pref2Icache_valid && !covered && !flush;
    assign do_issue       = issue_found && mem_grant && !flush;

    // Memory command and fill outputs, same cycle as the triggering inputs.
    always_comb begin
        proc2mem_command = MEM_NONE;
        proc2mem_addr    = '0;
        fill_valid       = 1'b0;
        fill_addr        = '0;
        fill_data        = '0;
        if (do_issue) begin
            proc2mem_command = MEM_LOAD;
            proc2mem_addr    = entries_q[issue_idx].addr;
        end
        if (fill_found) begin
            fill_valid = 1'b1;
            fill_addr  = entries_q[fill_idx].addr;
            fill_data  = mem2proc_data;
        end
    end

    // Next entry state. Alloc targets an INVALID slot, issue a REQ slot and
    // fill a PENDING slot, so the three updates never collide.
    always_comb begin
        entries_d = entries_q;
        if (flush) begin
            for (int i = 0; i < PREF_MSHR_SIZE; i++) begin
                if (entries_q[i].state == REQ) begin
                    entries_d[i].state = INVALID;
                end
            end
        end
        if (do_issue && (mem2proc_transaction_tag != 4'h0)) begin
            entries_d[issue_idx].state = PENDING;
            entries_d[issue_idx].tag   = mem2proc_transaction_tag;
        end
        if (fill_found) begin
            entries_d[fill_idx].state = INVALID;
            entries_d[fill_idx].tag   = 4'h0;
        end
        if (do_alloc) begin
            entries_d[alloc_idx].state = REQ;
            entries_d[alloc_idx].addr  = req_blk;
            entries_d[alloc_idx].tag   = 4'h0;
        end
    end

    // Entry storage; reset clears every slot immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PREF_MSHR_SIZE; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            entries_q <= entries_d;
        end
    end

endmodule
